id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Parametrised ID/EX pipeline stage for the 5-stage RISC-V core. It registers decode-stage control and datapath fields under a valid/ready handshake and supports stall by EX backpressure, flush with bubble insertion, and rs1/rs2 address pass-through for the hazard/forwarding unit. It sits between the decode stage and the execute stage and replaces a plain enable-less pipeline register.

Parameters:
XLEN, 32, datapath width of RD1/RD2/PC/ImmExt/PCPlus4
REG_AW, 5, register-file address width (rd, rs1, rs2)
ALUC_W, 3, ALU control field width
RESSRC_W, 2, result-source select width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  kill stage contents this cycle (branch/jump redirect)
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage accepts this cycle
out_valid  out  1  EX-side bundle valid
out_ready  in  1  EX accepts bundle this cycle
ctrl_d  in  5  {MemWrite, ALUSrc, RegWrite, Jump, Branch}
result_src_d  in  RESSRC_W  result source select
alu_ctrl_d  in  ALUC_W  ALU operation
rd_d, rs1_d, rs2_d  in  REG_AW each  dest/source register addresses
rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d  in  XLEN each  operands, PC, immediate, PC+4
ctrl_e, result_src_e, alu_ctrl_e, rd_e, rs1_e, rs2_e, rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e  out  matching widths  registered copies

Behaviour:
- Reset (reset==0 at clk edge): every output register 0; out_valid=0; in_ready=1 during reset cycle's next state.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Base mode: in_ready = !out_valid || out_ready (combinational). On transfer in, all fields captured, out_valid<=1, latency 1 cycle. Transfer out without transfer in: out_valid<=0.
- Stall: out_valid && !out_ready -> all outputs hold bit-exact; in_ready=0.
- Bubble rule: whenever out_valid==0, ctrl_e, result_src_e, alu_ctrl_e and rd_e are 0 (registered, not gated), so no write side effects leak. Data fields need not be cleared.
- Flush: priority reset > flush > everything else. flush==1 -> out_valid<=0, control fields and rd_e <=0, incoming bundle discarded even if in_valid (in_ready still reports the handshake value; transfer is dropped). Flush during stall clears held bundle.
- Simultaneous in and out transfer: new bundle replaces old, out_valid stays 1 (full throughput, one instruction/cycle).
- rd/rs1/rs2 all REG_AW wide; no truncation/extension anywhere.

Optional Feature:
ID_EX_SKID_EN: adds one-entry skid buffer; in_ready becomes registered (= !skid_valid), breaking the out_ready->in_ready combinational path. Bundle arriving while output stalled goes to skid; when out_ready, skid moves to output next edge. Flush/reset clear both entries. Without macro: base mode only, no skid storage, in_ready combinational as above.

Decomposition:
- Package id_ex_pkg: ctrl bit index constants (CTRL_MEMWRITE..CTRL_BRANCH), CTRL_W=5, packed struct id_ex_bundle_t parametrised by defaults, bubble constant.
- One sub-module natural: id_ex_skid_buf (one-entry holding register + valid), instantiated only under ID_EX_SKID_EN.

Test Plan:
- reset=0 2 cycles with in_valid=1, pc_d=32'h100 -> out_valid=0, all outputs 0; release -> pc_e=32'h100, out_valid=1 one cycle later.
- Back-to-back: pc_d 0x0,0x4,0x8 with out_ready=1 -> pc_e 0x0,0x4,0x8 on consecutive cycles, in_ready stays 1.
- Stall: out_ready=0 for 3 cycles holding rd_e=5'd7 -> rd_e stays 7, in_ready=0; pc_d changes ignored; release -> next bundle appears 1 cycle later.
- Flush with in_valid=1, ctrl_d=5'b00100 (RegWrite) -> next cycle out_valid=0, ctrl_e=0, rd_e=0.
- Flush during stall -> held bundle dropped, out_valid=0, in_ready=1 next cycle.
- ID_EX_SKID_EN: stall when bundle A held and B accepted -> B in skid, in_ready=0; out_ready=1 -> A then B out on consecutive cycles, no loss or duplication.

Source files
------------

// File: rtl/id_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pkg
// Brief    : Shared constants and bundle type for the ID/EX pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int ALUC_W_DEF   = 3;
  localparam int RESSRC_W_DEF = 2;

  // Control word layout: {MemWrite, ALUSrc, RegWrite, Jump, Branch}
  localparam int CTRL_W        = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef struct packed {
    logic [CTRL_W-1:0]       ctrl;
    logic [RESSRC_W_DEF-1:0] result_src;
    logic [ALUC_W_DEF-1:0]   alu_ctrl;
    logic [REG_AW_DEF-1:0]   rd;
    logic [REG_AW_DEF-1:0]   rs1;
    logic [REG_AW_DEF-1:0]   rs2;
    logic [XLEN_DEF-1:0]     rd1;
    logic [XLEN_DEF-1:0]     rd2;
    logic [XLEN_DEF-1:0]     pc;
    logic [XLEN_DEF-1:0]     imm_ext;
    logic [XLEN_DEF-1:0]     pc_plus4;
  } id_ex_bundle_t;

  localparam id_ex_bundle_t ID_EX_BUBBLE = '0;

endpackage : id_ex_pkg
`default_nettype wire

// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_if
// Brief    : Decode-side and execute-side handshake/bundle signals of ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_if
  import id_ex_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ALUC_W   = ALUC_W_DEF,
  parameter int RESSRC_W = RESSRC_W_DEF
) ();

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;

  logic [CTRL_W-1:0]   ctrl_d,       ctrl_e;
  logic [RESSRC_W-1:0] result_src_d, result_src_e;
  logic [ALUC_W-1:0]   alu_ctrl_d,   alu_ctrl_e;
  logic [REG_AW-1:0]   rd_d,         rd_e;
  logic [REG_AW-1:0]   rs1_d,        rs1_e;
  logic [REG_AW-1:0]   rs2_d,        rs2_e;
  logic [XLEN-1:0]     rd1_d,        rd1_e;
  logic [XLEN-1:0]     rd2_d,        rd2_e;
  logic [XLEN-1:0]     pc_d,         pc_e;
  logic [XLEN-1:0]     imm_ext_d,    imm_ext_e;
  logic [XLEN-1:0]     pc_plus4_d,   pc_plus4_e;

  modport slave (
    input  flush, in_valid, out_ready,
    input  ctrl_d, result_src_d, alu_ctrl_d, rd_d, rs1_d, rs2_d,
    input  rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d,
    output in_ready, out_valid,
    output ctrl_e, result_src_e, alu_ctrl_e, rd_e, rs1_e, rs2_e,
    output rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e
  );

  modport master (
    output flush, in_valid, out_ready,
    output ctrl_d, result_src_d, alu_ctrl_d, rd_d, rs1_d, rs2_d,
    output rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d,
    input  in_ready, out_valid,
    input  ctrl_e, result_src_e, alu_ctrl_e, rd_e, rs1_e, rs2_e,
    input  rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e
  );

endinterface : id_ex_if
`default_nettype wire

// File: rtl/id_ex_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_buf
// Brief    : One-entry holding register with valid flag for the ID/EX stage.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_skid_buf
  import id_ex_pkg::*;
#(
  parameter type T = id_ex_bundle_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic pop,
  input  T     data_in,
  output logic valid,
  output T     data
);

  logic r_valid;
  T     r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= data_in;
    end else if (pop) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule : id_ex_skid_buf
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with valid/ready handshake, stall, flush
//            and bubble insertion. Define ID_EX_SKID_EN for a one-entry skid
//            buffer with a registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int ALUC_W   = ALUC_W_DEF,
  parameter int RESSRC_W = RESSRC_W_DEF
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [CTRL_W-1:0]   ctrl;
    logic [RESSRC_W-1:0] result_src;
    logic [ALUC_W-1:0]   alu_ctrl;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     pc_plus4;
  } bundle_t;

  // An invalid slot must never carry a write side effect downstream.
  function automatic bundle_t kill_ctrl(input bundle_t b);
    bundle_t k;
    k            = b;
    k.ctrl       = '0;
    k.result_src = '0;
    k.alu_ctrl   = '0;
    k.rd         = '0;
    return k;
  endfunction

  bundle_t w_in;
  bundle_t r_out;
  logic    r_out_valid;
  logic    w_in_ready;
  logic    w_xfer_in;
  logic    w_out_fire;

  always_comb begin
    w_in            = '0;
    w_in.ctrl       = bus.ctrl_d;
    w_in.result_src = bus.result_src_d;
    w_in.alu_ctrl   = bus.alu_ctrl_d;
    w_in.rd         = bus.rd_d;
    w_in.rs1        = bus.rs1_d;
    w_in.rs2        = bus.rs2_d;
    w_in.rd1        = bus.rd1_d;
    w_in.rd2        = bus.rd2_d;
    w_in.pc         = bus.pc_d;
    w_in.imm_ext    = bus.imm_ext_d;
    w_in.pc_plus4   = bus.pc_plus4_d;
  end

  assign w_xfer_in  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;

`ifdef ID_EX_SKID_EN
  logic    w_out_open;
  logic    w_skid_valid;
  logic    w_skid_load;
  logic    w_skid_pop;
  bundle_t w_skid_data;

  assign w_out_open  = !r_out_valid || bus.out_ready;
  // in_ready depends only on flop state, so out_ready never reaches it.
  assign w_in_ready  = !w_skid_valid;
  assign w_skid_load = w_xfer_in && !w_out_open;
  assign w_skid_pop  = w_skid_valid && w_out_open;

  id_ex_skid_buf #(
    .T (bundle_t)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.flush),
    .load    (w_skid_load),
    .pop     (w_skid_pop),
    .data_in (w_in),
    .valid   (w_skid_valid),
    .data    (w_skid_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out       <= kill_ctrl(r_out);
      r_out_valid <= 1'b0;
    end else if (w_skid_pop) begin
      r_out       <= w_skid_data;
      r_out_valid <= 1'b1;
    end else if (w_xfer_in && w_out_open) begin
      r_out       <= w_in;
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out       <= kill_ctrl(r_out);
      r_out_valid <= 1'b0;
    end
  end
`else
  assign w_in_ready = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_out       <= kill_ctrl(r_out);
      r_out_valid <= 1'b0;
    end else if (w_xfer_in) begin
      r_out       <= w_in;
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out       <= kill_ctrl(r_out);
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.ctrl_e       = r_out.ctrl;
  assign bus.result_src_e = r_out.result_src;
  assign bus.alu_ctrl_e   = r_out.alu_ctrl;
  assign bus.rd_e         = r_out.rd;
  assign bus.rs1_e        = r_out.rs1;
  assign bus.rs2_e        = r_out.rs2;
  assign bus.rd1_e        = r_out.rd1;
  assign bus.rd2_e        = r_out.rd2;
  assign bus.pc_e         = r_out.pc;
  assign bus.imm_ext_e    = r_out.imm_ext;
  assign bus.pc_plus4_e   = r_out.pc_plus4;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard testbench for id_ex_stage (both ID_EX_SKID_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  id_ex_bundle_t q[$];
  id_ex_bundle_t cur;
  logic          zero_state = 1'b1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic id_ex_bundle_t observed();
    id_ex_bundle_t b;
    b.ctrl       = bus.ctrl_e;
    b.result_src = bus.result_src_e;
    b.alu_ctrl   = bus.alu_ctrl_e;
    b.rd         = bus.rd_e;
    b.rs1        = bus.rs1_e;
    b.rs2        = bus.rs2_e;
    b.rd1        = bus.rd1_e;
    b.rd2        = bus.rd2_e;
    b.pc         = bus.pc_e;
    b.imm_ext    = bus.imm_ext_e;
    b.pc_plus4   = bus.pc_plus4_e;
    return b;
  endfunction

  function automatic id_ex_bundle_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] ctrl);
    id_ex_bundle_t b;
    logic [31:0]   r;
    r            = $urandom;
    b.ctrl       = ctrl;
    b.result_src = r[1:0];
    b.alu_ctrl   = r[4:2];
    b.rd         = rd;
    b.rs1        = r[9:5];
    b.rs2        = r[14:10];
    b.rd1        = $urandom;
    b.rd2        = $urandom;
    b.pc         = pc;
    b.imm_ext    = $urandom;
    b.pc_plus4   = pc + 32'd4;
    return b;
  endfunction

  task automatic drive(input logic v, input logic r, input logic f, input id_ex_bundle_t b);
    cur              = b;
    bus.in_valid     = v;
    bus.out_ready    = r;
    bus.flush        = f;
    bus.ctrl_d       = b.ctrl;
    bus.result_src_d = b.result_src;
    bus.alu_ctrl_d   = b.alu_ctrl;
    bus.rd_d         = b.rd;
    bus.rs1_d        = b.rs1;
    bus.rs2_d        = b.rs2;
    bus.rd1_d        = b.rd1;
    bus.rd2_d        = b.rd2;
    bus.pc_d         = b.pc;
    bus.imm_ext_d    = b.imm_ext;
    bus.pc_plus4_d   = b.pc_plus4;
    @(posedge clk);
    #1;
  endtask

  // Reference model: q holds the bundles the stage currently owns, oldest first.
  always @(negedge clk) begin
    id_ex_bundle_t obs;
    logic          exp_ir;
    logic          acc;
    logic          fire;
    obs = observed();
`ifdef ID_EX_SKID_EN
    exp_ir = (q.size() < 2);
`else
    exp_ir = (q.size() == 0) || bus.out_ready;
`endif
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, exp_ir);
    if (q.size() != 0)
      check("bundle", obs, q[0]);
    else if (zero_state)
      check("reset_zero", obs, '0);
    else
      check("bubble_ctrl", {obs.ctrl, obs.result_src, obs.alu_ctrl, obs.rd}, '0);

    acc  = bus.in_valid && exp_ir;
    fire = (q.size() != 0) && bus.out_ready;
    if (!reset) begin
      q.delete();
      zero_state = 1'b1;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        zero_state = 1'b0;
      end
    end
  end

  initial begin
    id_ex_bundle_t idle;
    idle  = mk(32'h0, 5'd0, 5'b0);
    reset = 1'b0;

    drive(1'b1, 1'b1, 1'b0, mk(32'h100, 5'd3, 5'b00100));
    drive(1'b1, 1'b1, 1'b0, cur);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, cur);

    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b0, mk(32'(i * 4), 5'(i + 1), 5'b00101));

    drive(1'b1, 1'b1, 1'b0, mk(32'h20, 5'd7, 5'b00110));
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, mk(32'h40 + 32'(i * 4), 5'(i + 10), 5'b10000));
    drive(1'b0, 1'b1, 1'b0, idle);
    drive(1'b0, 1'b1, 1'b0, idle);
    drive(1'b0, 1'b1, 1'b0, idle);

    drive(1'b1, 1'b1, 1'b0, mk(32'h60, 5'd9, 5'b00100));
    drive(1'b1, 1'b1, 1'b1, mk(32'h64, 5'd10, 5'b00100));
    drive(1'b0, 1'b1, 1'b0, idle);

    drive(1'b1, 1'b1, 1'b0, mk(32'h80, 5'd11, 5'b01100));
    drive(1'b1, 1'b0, 1'b0, mk(32'h84, 5'd12, 5'b00100));
    drive(1'b1, 1'b0, 1'b1, mk(32'h88, 5'd13, 5'b00100));
    drive(1'b0, 1'b1, 1'b0, idle);
    drive(1'b0, 1'b1, 1'b0, idle);

    drive(1'b1, 1'b0, 1'b0, mk(32'hA0, 5'd14, 5'b00100));
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, mk(32'hA4, 5'd15, 5'b00100));
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, idle);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
            mk($urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))));

    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b0, idle);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
